// File: rtl/mix_columns_serial_if.sv
// Handshake bundle for the MixColumns stage.
//   in_valid/in_ready   : upstream handshake; a block moves when both are 1 at a rising edge.
//   in_data/in_bypass   : block payload, valid with in_valid (must be held while in_ready=0).
//   out_valid/out_ready : downstream handshake; out_data is held stable while out_valid=1 and out_ready=0.
//   out_data            : mixed (or bypassed) state, column-major, row0 byte in the MSB of each column.
// Modports: slave = the stage itself, master = the block driving/consuming it.
interface mix_columns_serial_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport slave (
        input  in_valid, in_data, in_bypass, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_bypass, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mix_columns_serial.sv
// AES MixColumns / InvMixColumns round stage, column-serial.
// Sits between ShiftRows and AddRoundKey. A block is latched in IDLE, mixed
// COLS_PER_CYCLE columns per clock in CALC, then presented in DONE until the
// downstream takes it. in_bypass skips the mixing (final round).
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous, active-high reset
//   bus         : slave side of mix_columns_serial_if (in/out valid/ready handshakes, data)
//   busy        : FSM is not IDLE
//   dbg_state_o : raw FSM state (0 IDLE, 1 CALC, 2 DONE)
// Parameters:
//   COLS_PER_CYCLE : 1, 2 or 4 columns mixed per CALC cycle
//   INVERSE        : 0 MixColumns {02,03,01,01}, 1 InvMixColumns {0e,0b,0d,09}
module mix_columns_serial #(
    parameter int COLS_PER_CYCLE = 1,
    parameter int INVERSE        = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    mix_columns_serial_if.slave  bus,
    output logic                 busy,
    output logic [1:0]           dbg_state_o
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_serial: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // col_idx is 2 bits: a step of 4 wraps to 0, so the last group always starts at 4-COLS_PER_CYCLE.
    localparam logic [1:0] STEP     = COLS_PER_CYCLE[1:0];
    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

    state_t       state_q, state_d;
    logic [1:0]   col_idx_q;
    logic [127:0] src_q;
    logic [127:0] res_q;
    logic         out_valid_q;
    logic [127:0] out_data_q;
    logic         in_ready;
    logic         accept;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0]  a  [4];
        logic [7:0]  m2 [4];
        logic [7:0]  m4 [4];
        logic [7:0]  m8 [4];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (INVERSE == 0) begin
                // 2*a[i] ^ 3*a[i+1] ^ a[i+2] ^ a[i+3]
                r[31-8*i -: 8] = m2[i] ^ m2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
            end else begin
                // e*a[i] ^ b*a[i+1] ^ d*a[i+2] ^ 9*a[i+3]
                r[31-8*i -: 8] = (m8[i] ^ m4[i] ^ m2[i])
                               ^ (m8[(i+1)%4] ^ m2[(i+1)%4] ^ a[(i+1)%4])
                               ^ (m8[(i+2)%4] ^ m4[(i+2)%4] ^ a[(i+2)%4])
                               ^ (m8[(i+3)%4] ^ a[(i+3)%4]);
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Column mixers: only COLS_PER_CYCLE of them, fed by a column mux on src.
    // Column c lives at bits [32*(3-c) +: 32]; 3-c is ~c for a 2-bit index.
    // ------------------------------------------------------------------
    logic [1:0]  sel   [COLS_PER_CYCLE];
    logic [31:0] mixed [COLS_PER_CYCLE];

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mix
        assign sel[k]   = col_idx_q + 2'(k);
        assign mixed[k] = mix_col(src_q[{~sel[k], 5'b0} +: 32]);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = bus.in_bypass ? DONE : CALC;
            CALC: if (col_idx_q == LAST_IDX) state_d = DONE;
            DONE: if (out_valid_q && bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready    = (state_q == IDLE) && !rst;
        busy        = (state_q != IDLE) && !rst;
        dbg_state_o = state_q;
    end

    assign accept = bus.in_valid && in_ready;

    // ------------------------------------------------------------------
    // Control/output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx_q   <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 128'h0;
        end else begin
            case (state_q)
                IDLE: if (accept) col_idx_q <= 2'd0;
                CALC: col_idx_q <= col_idx_q + STEP;
                DONE: begin
                    // out_valid rises one cycle after DONE is entered and drops
                    // on the edge that completes the output handshake.
                    out_valid_q <= !(out_valid_q && bus.out_ready);
                    out_data_q  <= res_q;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers (no reset needed: contents are qualified by the FSM)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_q == IDLE && accept) begin
            src_q <= bus.in_data;
            if (bus.in_bypass) begin
                res_q <= bus.in_data;
            end
        end else if (state_q == CALC) begin
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                res_q[{~sel[k], 5'b0} +: 32] <= mixed[k];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_mix_columns_serial.sv
module tb_mix_columns_serial;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_bypass = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_ready = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Four DUTs: fwd with 1/2/4 columns per cycle, inverse with 1.
    logic         irdy [4];
    logic         ov   [4];
    logic [127:0] od   [4];
    logic         bsy  [4];
    logic [1:0]   dbg  [4];

    for (genvar d = 0; d < 4; d++) begin : g_dut
        localparam int CPC = (d == 2) ? 4 : (d == 1) ? 2 : 1;
        localparam int INV = (d == 3) ? 1 : 0;
        mix_columns_serial_if bus_if ();
        assign bus_if.in_valid  = in_valid;
        assign bus_if.in_bypass = in_bypass;
        assign bus_if.in_data   = in_data;
        assign bus_if.out_ready = out_ready;
        assign irdy[d] = bus_if.in_ready;
        assign ov[d]   = bus_if.out_valid;
        assign od[d]   = bus_if.out_data;
        logic busy_w;
        logic [1:0] dbg_w;
        mix_columns_serial #(.COLS_PER_CYCLE(CPC), .INVERSE(INV)) dut (
            .clk(clk), .rst(rst), .bus(bus_if.slave), .busy(busy_w), .dbg_state_o(dbg_w)
        );
        assign bsy[d] = busy_w;
        assign dbg[d] = dbg_w;
    end

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] block_ref(input logic [127:0] blk, input bit inv);
        logic [7:0]   cf [4];
        logic [7:0]   a  [4];
        logic [7:0]   r;
        logic [127:0] o;
        cf[0] = inv ? 8'h0e : 8'h02;
        cf[1] = inv ? 8'h0b : 8'h03;
        cf[2] = inv ? 8'h0d : 8'h01;
        cf[3] = inv ? 8'h09 : 8'h01;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = blk[127-32*c-8*j -: 8];
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gmul(a[j], cf[(j - i + 4) % 4]);
                o[127-32*c-8*i -: 8] = r;
            end
        end
        return o;
    endfunction

    function automatic int cpc_of(input int d);
        return (d == 2) ? 4 : (d == 1) ? 2 : 1;
    endfunction

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q [4][$];
    bit           acc_pend [4];
    bit           acc_byp  [4];
    int           acc_cyc  [4];
    logic         ov_prev  [4];

    initial for (int d = 0; d < 4; d++) begin
        acc_pend[d] = 0; acc_byp[d] = 0; acc_cyc[d] = 0; ov_prev[d] = 0;
    end

    // Samples on the falling edge; inputs change 1ns after the rising edge.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rst) begin
                acc_pend[d] = 0;
            end else begin
                if (in_valid && irdy[d]) begin
                    acc_pend[d] = 1;
                    acc_cyc[d]  = cyc + 1;
                    acc_byp[d]  = in_bypass;
                end
                if (ov[d] && !ov_prev[d]) begin
                    n_cmp++;
                    assert (acc_pend[d] === 1'b1) else begin
                        n_fail++;
                        $error("FAIL out_valid_without_accept dut%0d: observed rise, required none", d);
                    end
                    if (acc_pend[d]) begin
                        int lat;
                        int lat_exp;
                        lat     = cyc - acc_cyc[d];
                        lat_exp = acc_byp[d] ? 1 : 1 + 4 / cpc_of(d);
                        n_cmp++;
                        assert (lat === lat_exp) else begin
                            n_fail++;
                            $error("FAIL latency dut%0d: observed %0d required %0d", d, lat, lat_exp);
                        end
                        acc_pend[d] = 0;
                    end
                end
                if (ov[d] && out_ready) begin
                    n_cmp++;
                    assert (exp_q[d].size() != 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_output dut%0d: observed %h required nothing", d, od[d]);
                    end
                    if (exp_q[d].size() != 0) begin
                        logic [127:0] e;
                        e = exp_q[d].pop_front();
                        n_cmp++;
                        assert (od[d] === e) else begin
                            n_fail++;
                            $error("FAIL out_data dut%0d: observed %h required %h", d, od[d], e);
                        end
                    end
                end
            end
            ov_prev[d] = ov[d];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic bit all_ready();
        return irdy[0] && irdy[1] && irdy[2] && irdy[3];
    endfunction

    task automatic send(input logic [127:0] data, input logic byp,
                        input logic [127:0] ef, input logic [127:0] ei);
        int t;
        t = 0;
        while (!all_ready() && t < 50) begin
            tick();
            t++;
        end
        n_cmp++;
        assert (t < 50) else begin
            n_fail++;
            $error("FAIL send_timeout: observed %0d cycles required <50", t);
        end
        in_data   = data;
        in_bypass = byp;
        in_valid  = 1'b1;
        for (int d = 0; d < 4; d++) exp_q[d].push_back(byp ? data : (d == 3 ? ei : ef));
        tick();
        in_valid  = 1'b0;
        in_bypass = 1'b0;
    endtask

    task automatic send_model(input logic [127:0] data);
        send(data, 1'b0, block_ref(data, 1'b0), block_ref(data, 1'b1));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (!(exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 &&
                 exp_q[3].size() == 0 && all_ready()) && t < 100) begin
            tick();
            t++;
        end
        n_cmp++;
        assert (t < 100) else begin
            n_fail++;
            $error("FAIL drain_timeout: observed %0d cycles required <100", t);
        end
    endtask

    // ---------------- directed sequence ----------------
    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] COL_IN   = 128'hdb135345f20a225c01010101d4d4d4d5;
    localparam logic [127:0] COL_OUT  = 128'h8e4da1bc9fdc589d01010101d5d5d7d6;
    localparam logic [127:0] BYP_IN   = 128'h00112233445566778899aabbccddeeff;

    initial begin
        logic [127:0] hold [4];

        // Reset
        rst = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_in_ready%0d", d), 128'(irdy[d]), 128'd0);
            chk($sformatf("rst_busy%0d", d), 128'(bsy[d]), 128'd0);
        end
        rst = 1'b0;
        tick();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("post_rst_out_valid%0d", d), 128'(ov[d]), 128'd0);
            chk($sformatf("post_rst_out_data%0d", d), od[d], 128'h0);
            chk($sformatf("post_rst_in_ready%0d", d), 128'(irdy[d]), 128'd1);
            chk($sformatf("post_rst_state%0d", d), 128'(dbg[d]), 128'd0);
        end

        // FIPS-197 App. B round 1, forward and its inverse
        send(FIPS_IN, 1'b0, FIPS_OUT, block_ref(FIPS_IN, 1'b1));
        drain();
        send(FIPS_OUT, 1'b0, block_ref(FIPS_OUT, 1'b0), FIPS_IN);
        drain();

        // Known column vectors packed into one block
        send(COL_IN, 1'b0, COL_OUT, block_ref(COL_IN, 1'b1));
        drain();

        // Random blocks against the model, plus edge patterns
        send_model(128'h0);
        drain();
        send_model({128{1'b1}});
        drain();
        for (int i = 0; i < 4; i++) begin
            send_model({$urandom, $urandom, $urandom, $urandom});
            drain();
        end

        // Bypass
        send(BYP_IN, 1'b1, BYP_IN, BYP_IN);
        drain();

        // Backpressure: stall 10 cycles in DONE, in_valid pulses ignored
        out_ready = 1'b0;
        send_model({$urandom, $urandom, $urandom, $urandom});
        begin
            int t;
            t = 0;
            while (!(ov[0] && ov[1] && ov[2] && ov[3]) && t < 20) begin
                tick();
                t++;
            end
            n_cmp++;
            assert (t < 20) else begin
                n_fail++;
                $error("FAIL stall_valid_timeout: observed %0d cycles required <20", t);
            end
        end
        for (int d = 0; d < 4; d++) hold[d] = exp_q[d][0];
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("stall_data%0d_c%0d", d, c), od[d], hold[d]);
                chk($sformatf("stall_in_ready%0d_c%0d", d, c), 128'(irdy[d]), 128'd0);
                chk($sformatf("stall_valid%0d_c%0d", d, c), 128'(ov[d]), 128'd1);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("release_in_ready%0d", d), 128'(irdy[d]), 128'd1);
            chk($sformatf("release_valid%0d", d), 128'(ov[d]), 128'd0);
            chk($sformatf("release_pending%0d", d), 128'(exp_q[d].size()), 128'd0);
        end

        // Reset one cycle after accept: block is dropped
        send_model({$urandom, $urandom, $urandom, $urandom});
        rst = 1'b1;
        for (int d = 0; d < 4; d++) exp_q[d].delete();
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("midrst_in_ready%0d", d), 128'(irdy[d]), 128'd0);
            chk($sformatf("midrst_busy%0d", d), 128'(bsy[d]), 128'd0);
        end
        tick();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 4; d++)
            chk($sformatf("after_rst_in_ready%0d", d), 128'(irdy[d]), 128'd1);
        for (int c = 0; c < 8; c++) tick();
        for (int d = 0; d < 4; d++)
            chk($sformatf("dropped_no_valid%0d", d), 128'(ov[d]), 128'd0);
        send(FIPS_IN, 1'b0, FIPS_OUT, block_ref(FIPS_IN, 1'b1));
        drain();

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
